// File: rtl/imem_loader_fetch_if.sv
// Loader/fetch bus for imem_loader_fetch.
// The master side (loader and core) drives requests; the slave side is the memory block.
interface imem_loader_fetch_if;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_done;
  logic        ld_err;
  logic        reload;
  logic        fetch_req;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_fault;
  logic        mem_ready;

  modport master (
    output ld_valid, ld_addr, ld_data, ld_done, reload, fetch_req, pc,
    input  ld_ready, ld_err, instr, instr_valid, fetch_fault, mem_ready
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_done, reload, fetch_req, pc,
    output ld_ready, ld_err, instr, instr_valid, fetch_fault, mem_ready
  );
endinterface

// File: rtl/imem_loader_fetch.sv
// Instruction memory with a clear/load/run lifecycle: self-fills with NOP_WORD after reset,
// accepts loader writes, then serves single-cycle registered fetches.
module imem_loader_fetch #(
  parameter int unsigned DEPTH    = 256,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic clk,
  input  logic reset,
  imem_loader_fetch_if.slave bus
);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt;
  logic [31:0]   mem [DEPTH];

  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [31:0]   mem_wd;
  logic          ld_ready, mem_ready;
  logic          ld_acc, ld_ok, fe_go, fe_ok;
  logic          ld_err_q, instr_valid_q, fetch_fault_q;
  logic [31:0]   instr_q;

  // Full-width range checks so high address bits can never alias into the array.
  assign ld_ok = (bus.ld_addr[1:0] == 2'b00) && ((bus.ld_addr >> 2) < DEPTH_W);
  assign fe_ok = (bus.pc[1:0] == 2'b00) && ((bus.pc >> 2) < DEPTH_W);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    mem_ready = 1'b0;
    ld_acc    = 1'b0;
    fe_go     = 1'b0;
    mem_we    = 1'b0;
    mem_wa    = cnt;
    mem_wd    = NOP_WORD;
    case (state)
      CLEAR: begin
        mem_we = 1'b1;
        if (cnt == LAST) state_nxt = LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        ld_acc   = bus.ld_valid;
        if (ld_acc && ld_ok) begin
          mem_we = 1'b1;
          mem_wa = bus.ld_addr[AW+1:2];
          mem_wd = bus.ld_data;
        end
        if (bus.ld_done) state_nxt = RUN;
      end
      RUN: begin
        mem_ready = 1'b1;
        fe_go     = bus.fetch_req;
        if (bus.reload) state_nxt = LOAD;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // cnt wraps back to 0 as CLEAR finishes, ready for the next reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               cnt <= '0;
    else if (state == CLEAR) cnt <= cnt + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ld_err_q <= 1'b0;
    else        ld_err_q <= ld_acc && !ld_ok;
  end

  // instr only updates on a fetch; faulting fetches return the NOP word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      instr_valid_q <= fe_go;
      fetch_fault_q <= fe_go && !fe_ok;
      if (fe_go) instr_q <= fe_ok ? mem[bus.pc[AW+1:2]] : NOP_WORD;
    end
  end

  assign bus.ld_ready    = ld_ready;
  assign bus.mem_ready   = mem_ready;
  assign bus.ld_err      = ld_err_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.fetch_fault = fetch_fault_q;
endmodule
